// File: rtl/pipe_pkg.sv
// Shared Y86 pipeline constants and hazard-controller state type.
package pipe_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // "No register" identifier
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  // True for any status that stops the pipeline
  function automatic logic is_exc(input logic [2:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_cnt;

  // Count up on inc, stick at all-ones, clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign q = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86 pipeline hazard controller: stall/bubble generation, memory-wait and
// exception-drain state machine, and saturating hazard event counters.
module pipe_hazard_ctrl #(
  parameter int               REG_W        = 4,
  parameter logic [REG_W-1:0] RNONE        = REG_W'(4'hF),
  parameter int               CNT_W        = 32,
  parameter bit               DMEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [REG_W-1:0] d_srcA,
  input  logic [REG_W-1:0] d_srcB,
  input  logic [REG_W-1:0] E_dstM,
  input  logic             e_Cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_mispred,
  output logic [CNT_W-1:0] cnt_ret,
  output logic [CNT_W-1:0] cnt_memwait
);

  import pipe_pkg::*;

  state_e r_state;
  state_e w_state_nxt;

  logic w_lu, w_mp, w_rt, w_memop, w_mw, w_exc, w_wexc;
  logic w_run_cnt, w_inc_lu, w_inc_mp, w_inc_ret, w_inc_mw;

  // RNONE never matches, so an instruction without a memory destination
  // cannot create a load/use hazard.
  assign w_lu    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_mp    = (E_icode == I_JXX) && !e_Cnd;
  assign w_rt    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign w_memop = (M_icode == I_RMMOVQ) || (M_icode == I_MRMOVQ) || (M_icode == I_CALL) ||
                   (M_icode == I_RET)    || (M_icode == I_PUSHQ)  || (M_icode == I_POPQ);
  assign w_mw    = DMEM_WAIT_EN && w_memop && !dmem_ready;
  assign w_exc   = is_exc(m_stat);
  assign w_wexc  = is_exc(W_stat);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state selection; a writeback exception wins from every live state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_wexc)     w_state_nxt = ST_HALT;
        else if (w_exc) w_state_nxt = ST_DRAIN;
        else if (w_mw)  w_state_nxt = ST_MEMWAIT;
      end
      ST_MEMWAIT: begin
        if (w_wexc)          w_state_nxt = ST_HALT;
        else if (dmem_ready) w_state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (w_wexc) w_state_nxt = ST_HALT;
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  // Pipeline controls; a memory wait freezes F..M and drops the D/E bubbles
  // because those registers are already being held.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    halted   = 1'b0;
    case (r_state)
      ST_HALT: begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        E_stall = 1'b1;
        M_stall = 1'b1;
        W_stall = 1'b1;
        halted  = 1'b1;
      end
      ST_DRAIN: begin
        F_stall  = 1'b1;
        M_bubble = 1'b1;
        W_stall  = w_wexc;
      end
      default: begin
        if ((r_state == ST_MEMWAIT) && !dmem_ready) begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          E_stall  = 1'b1;
          M_stall  = 1'b1;
          W_bubble = 1'b1;
        end else begin
          F_stall  = w_lu | w_rt | w_mw;
          D_stall  = w_lu | w_mw;
          E_stall  = w_mw;
          M_stall  = w_mw;
          D_bubble = !w_mw && (w_mp || (w_rt && !w_lu));
          E_bubble = !w_mw && (w_mp || w_lu);
          M_bubble = w_exc | w_wexc;
          W_stall  = w_wexc;
          W_bubble = w_mw;
        end
      end
    endcase
    set_cc = (E_icode == I_OPQ) && !w_exc && !w_wexc && !w_mw &&
             ((r_state == ST_RUN) || (r_state == ST_MEMWAIT));
    if (!rst_n) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      E_stall  = 1'b0;
      M_stall  = 1'b0;
      W_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_bubble = 1'b0;
      set_cc   = 1'b0;
      halted   = 1'b0;
    end
  end

  assign state_o = r_state;

  // Hazard events are only counted while the pipeline is actually advancing
  assign w_run_cnt = (r_state == ST_RUN) && !w_mw;
  assign w_inc_lu  = w_run_cnt && w_lu;
  assign w_inc_mp  = w_run_cnt && w_mp;
  assign w_inc_ret = w_run_cnt && w_rt && (!w_lu || w_mp);
  assign w_inc_mw  = ((r_state == ST_RUN) && w_mw) || ((r_state == ST_MEMWAIT) && !dmem_ready);

  sat_counter #(.WIDTH(CNT_W)) u_cnt_loaduse (
    .clk(clk), .rst_n(rst_n), .clr(perf_clr), .inc(w_inc_lu), .q(cnt_loaduse));
  sat_counter #(.WIDTH(CNT_W)) u_cnt_mispred (
    .clk(clk), .rst_n(rst_n), .clr(perf_clr), .inc(w_inc_mp), .q(cnt_mispred));
  sat_counter #(.WIDTH(CNT_W)) u_cnt_ret (
    .clk(clk), .rst_n(rst_n), .clr(perf_clr), .inc(w_inc_ret), .q(cnt_ret));
  sat_counter #(.WIDTH(CNT_W)) u_cnt_memwait (
    .clk(clk), .rst_n(rst_n), .clr(perf_clr), .inc(w_inc_mw), .q(cnt_memwait));

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised, stateful successor to the Y86 pipeline hazard controller.
- Generates stall/bubble/set_cc controls for F/D/E/M/W from stage icodes, register IDs, branch outcome and status codes.
- Adds four things the current controller lacks:
  - data-memory wait handshake;
  - exception drain/halt state machine;
  - RNONE-aware load/use detection;
  - saturating hazard performance counters.
- Sits beside the pipeline registers in the top-level processor.

Parameters:
- REG_W, 4, register-ID width
- RNONE, 4'hF, "no register" encoding; never matches as a hazard source
- CNT_W, 32, performance counter width
- DMEM_WAIT_EN, 1, 1 = honour dmem_ready; 0 = memory always ready

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- D_icode, E_icode, M_icode  in  4 each  stage icodes
- d_srcA, d_srcB  in  REG_W  decode-stage source registers
- E_dstM  in  REG_W  execute-stage memory destination
- e_Cnd  in  1  execute-stage branch condition
- m_stat, W_stat  in  3  status (1 AOK, 2 HLT, 3 ADR, 4 INS)
- dmem_ready  in  1  data memory completes access this cycle
- perf_clr  in  1  synchronous counter clear
- F_stall, D_stall, E_stall, M_stall, W_stall  out  1 each  hold stage register
- D_bubble, E_bubble, M_bubble, W_bubble  out  1 each  insert nop
- set_cc  out  1  enable condition-code update
- halted  out  1  core stopped
- state_o  out  2  FSM state (0 RUN, 1 MEMWAIT, 2 DRAIN, 3 HALT)
- cnt_loaduse, cnt_mispred, cnt_ret, cnt_memwait  out  CNT_W each  event counters

Behaviour:
- Reset (rst_n low, async):
  - state = RUN; all counters = 0.
  - All stall/bubble/set_cc/halted outputs forced 0 while rst_n is low.
- Hazard terms (combinational):
  - lu = (E_icode in {5, B}) && E_dstM != RNONE && (E_dstM == d_srcA || E_dstM == d_srcB).
  - mp = E_icode == 7 && !e_Cnd.
  - rt = 9 in {D_icode, E_icode, M_icode}.
  - memop = M_icode in {4, 5, 8, 9, A, B}.
  - mw = DMEM_WAIT_EN && memop && !dmem_ready.
  - exc = m_stat in {2, 3, 4}; wexc = W_stat in {2, 3, 4}.
- FSM transitions (registered, priority top-down):
  - RUN: wexc -> HALT; exc -> DRAIN; mw -> MEMWAIT; else stay.
  - MEMWAIT: wexc -> HALT; dmem_ready -> RUN; else stay.
  - DRAIN: wexc -> HALT; else stay.
  - HALT: absorbing; exit only via reset.
- Outputs, RUN:
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mp | (rt & !lu).
  - E_bubble = mp | lu.
  - E_stall = M_stall = 0.
  - M_bubble = exc | wexc.
  - W_stall = wexc.
  - W_bubble = mw (combinational entry into MEMWAIT).
  - When mw is asserted: F, D, E and M stall are also forced to 1, and mp/lu bubbles are suppressed.
- Outputs, MEMWAIT:
  - F/D/E/M_stall = !dmem_ready; W_bubble = !dmem_ready; other bubbles 0.
  - The cycle dmem_ready rises, controls equal the RUN equations.
- Outputs, DRAIN:
  - M_bubble = 1; F_stall = 1; D_bubble = 0; E_bubble = 0; W_stall = wexc.
- Outputs, HALT:
  - All *_stall = 1; all bubbles 0; halted = 1.
- set_cc = (E_icode == 6) && !exc && !wexc && state in {RUN, MEMWAIT} && !mw.
- Counters (per cycle, only in RUN, and not when mw):
  - cnt_loaduse += lu; cnt_mispred += mp.
  - cnt_ret += (rt & !lu) | (rt & mp), i.e. cycles with a ret bubble.
  - cnt_memwait += 1 for each cycle with mw or state == MEMWAIT.
  - All counters saturate at 2^CNT_W - 1.
  - perf_clr zeroes all counters next edge; clear wins over a simultaneous increment.
- Mispredict combined with ret in D: D_bubble = 1 and F_stall = 1, matching the CS:APP combination rule.

Decomposition:
- Shared package pipe_pkg: icode constants (I_HALT..I_POPQ), stat constants (S_AOK, S_HLT, S_ADR, S_INS), RNONE, and the FSM state enum.
- One natural sub-module: sat_counter (width parameter, inc, clr, saturating), instantiated four times.

Test Plan:
- mrmovq in E with E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0, cnt_loaduse=1; repeat with E_dstM=F -> no stall.
- E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; next cycle cnt_mispred=1.
- ret traverses D, E, M -> F_stall=1 and D_bubble=1 for 3 cycles, cnt_ret=3; in the first cycle, also hold lu -> D_stall=1 and D_bubble=0.
- M_icode=5, dmem_ready low 4 cycles -> state=MEMWAIT, F/D/E/M_stall=1, W_bubble=1 for 4 cycles, set_cc=0, cnt_memwait=4; RUN on ready.
- m_stat=3 with E_icode=6 -> set_cc=0, M_bubble=1, state=DRAIN; W_stat=3 next -> HALT, halted=1, all stalls 1; persists until rst_n low asynchronously clears.
- Counter at max with lu -> holds at max; perf_clr with lu same cycle -> counter=0.
